vliw_slot_sequencer: RTL and testbench
======================================

VLIW_SLOT_SEQUENCER -- requirements
Module: vliw_slot_sequencer

Interface
REQ-001 SHALL have parameter BUNDLE_W, default 1024, meaning bundle width in bits (multiple of 8, ≥64).
REQ-002 SHALL have parameter LANES, default 2, meaning slots issued per beat (1..4).
REQ-003 SHALL derive MAX_SLOTS = (BUNDLE_W-40)/24 (41 at default).
REQ-004 SHALL have clk  input  1  sole clock, rising edge.
REQ-005 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have in_valid input 1, in_ready output 1, in_bundle input BUNDLE_W: bundle handshake.
REQ-007 SHALL have out_valid output 1, out_ready input 1: slot-beat handshake.
REQ-008 SHALL have out_code, out_src, out_dst outputs LANES*8 each: lane k in bits [8k+7:8k].
REQ-009 SHALL have out_lane_en output LANES, out_last output 1, out_next output 16.
REQ-010 SHALL have meta_valid output 1, meta_ready input 1, meta_operand output 16, meta_next output 16.
REQ-011 SHALL have len_err output 1: one-cycle pulse on eval_len clamp.

Function
REQ-012 Bundle layout SHALL be: [W-1] meta; [W-2:W-8] eval_len; [W-9:W-24] operand; [W-25:W-40] next; slot i at [24i+23:24i] = {code[23:16], src[15:8], dst[7:0]}.
REQ-013 FSM states SHALL be IDLE, ISSUE, META; in_ready = 1 only in IDLE.
REQ-014 On in_valid&&in_ready the bundle SHALL be registered; meta=1 → META, else → ISSUE with slot index idx=0.
REQ-015 n SHALL be eval_len; if eval_len > MAX_SLOTS, n = MAX_SLOTS and len_err SHALL pulse the cycle after accept.
REQ-016 out_valid/meta_valid SHALL assert the cycle after accept (latency 1) and all outputs SHALL depend on registers only.
REQ-017 In ISSUE, a beat SHALL present slots idx..idx+LANES-1; out_lane_en[k] = (idx+k < n); disabled lanes SHALL drive zero.
REQ-018 out_last SHALL be 1 when idx+LANES ≥ n; out_next SHALL equal bundle next on every beat.
REQ-019 On out_valid&&out_ready idx SHALL advance by LANES; on last beat state → IDLE.
REQ-020 n=0 SHALL produce exactly one beat with out_lane_en=0, out_last=1.
REQ-021 While out_ready=0 (or meta_ready=0), all beat outputs SHALL hold stable and idx SHALL not change.
REQ-022 In META, meta_operand/meta_next SHALL show bundle fields; meta_valid&&meta_ready → IDLE; no out_valid in META.
REQ-023 Beat count per bundle SHALL be max(1, ceil(n/LANES)); one IDLE cycle separates bundles.
REQ-024 idx SHALL be 8 bits; no wrap occurs since n ≤ 127.

Reset
REQ-025 rst SHALL force IDLE, idx=0, bundle register=0, and every output 0 except in_ready=1 in the following cycle.
REQ-026 rst mid-ISSUE or mid-META SHALL discard the bundle with no further beats; rst overrides simultaneous handshakes.

Structure
REQ-027 Package vliw_pkg SHALL hold header bit offsets, SLOT_W=24, field widths (8/7/16/16), and state enum.
REQ-028 Sub-module vliw_slot_extract (combinational: bundle, idx, n → per-lane code/src/dst/en) SHALL be used.
REQ-029 Target size: 120-400 lines RTL total.

Verification (BUNDLE_W=1024, LANES=2)
REQ-030 eval_len=5, slot i code=i+1, next=0x1234 → 3 beats, lane_en 11,11,01, codes (1,2),(3,4),(5,0), last on beat 3, out_next=0x1234.
REQ-031 Same bundle, out_ready=0 for 3 cycles at beat 2 → beat 2 outputs unchanged, 3 total beats.
REQ-032 meta=1, operand=0xBEEF, next=0x0042, meta_ready delayed 2 cycles → meta_valid at t+1 held 3 cycles, no out_valid, in_ready=0 until IDLE.
REQ-033 eval_len=100 → len_err single pulse, 21 beats, final lane_en=01.
REQ-034 eval_len=0 → one beat, lane_en=00, out_last=1.
REQ-035 rst after beat 1 of eval_len=5 → next cycle out_valid=0, in_ready=1, idx=0.

Source files
------------

// File: rtl/vliw_pkg.sv
// Shared definitions for the VLIW slot sequencer: bundle header layout,
// slot/field widths and the sequencer state encoding.
package vliw_pkg;

    // Slot and header field widths
    localparam int SLOT_W    = 24;
    localparam int CODE_W    = 8;
    localparam int LEN_W     = 7;
    localparam int OPERAND_W = 16;
    localparam int NEXT_W    = 16;
    localparam int HDR_W     = 40;
    localparam int IDX_W     = 8;

    // Header field positions, as offsets below the bundle width:
    // the field's top bit sits at BUNDLE_W - <OFS>.
    localparam int META_OFS    = 1;
    localparam int LEN_OFS     = 2;
    localparam int OPERAND_OFS = 9;
    localparam int NEXT_OFS    = 25;

    // Slot word sub-fields: {code, src, dst}
    localparam int CODE_LSB = 16;
    localparam int SRC_LSB  = 8;
    localparam int DST_LSB  = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        META  = 2'd2
    } state_t;

    // Number of whole slots that fit behind the header
    function automatic int max_slots(input int bundle_w);
        return (bundle_w - HDR_W) / SLOT_W;
    endfunction

endpackage

// File: rtl/vliw_slot_extract.sv
// Combinational lane selector: picks slots idx..idx+LANES-1 out of the
// registered bundle, enabling only lanes whose slot index is below n.
module vliw_slot_extract
    import vliw_pkg::*;
#(
    parameter int BUNDLE_W  = 1024,
    parameter int LANES     = 2,
    parameter int MAX_SLOTS = 41
) (
    input  logic [BUNDLE_W-1:0] bundle,
    input  logic [IDX_W-1:0]    idx,
    input  logic [LEN_W-1:0]    n,
    output logic [LANES*8-1:0]  code,
    output logic [LANES*8-1:0]  src,
    output logic [LANES*8-1:0]  dst,
    output logic [LANES-1:0]    en
);

    // Header bits and any tail bits beyond the last whole slot are not
    // consumed here; fold them away so they do not appear dangling.
    logic unused_bundle_bits;
    assign unused_bundle_bits = ^bundle;

    logic [SLOT_W-1:0] slots [MAX_SLOTS];

    genvar gi;
    generate
        for (gi = 0; gi < MAX_SLOTS; gi++) begin : g_slot
            assign slots[gi] = bundle[SLOT_W*gi +: SLOT_W];
        end

        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [IDX_W:0]    slot_num;
            logic              lane_en;
            logic [SLOT_W-1:0] word;

            assign slot_num = {1'b0, idx} + (IDX_W+1)'(gi);
            assign lane_en  = slot_num < {2'b00, n};

            // Wide mux over slot positions; disabled lanes resolve to zero
            always_comb begin
                word = '0;
                for (int s = 0; s < MAX_SLOTS; s++) begin
                    if (lane_en && slot_num == (IDX_W+1)'(s)) begin
                        word = slots[s];
                    end
                end
            end

            assign en[gi]          = lane_en;
            assign code[8*gi +: 8] = word[CODE_LSB +: 8];
            assign src[8*gi +: 8]  = word[SRC_LSB +: 8];
            assign dst[8*gi +: 8]  = word[DST_LSB +: 8];
        end
    endgenerate

endmodule

// File: rtl/vliw_slot_sequencer.sv
// Accepts one VLIW bundle at a time and issues its slots LANES per beat,
// or presents the bundle's operand/next fields for a meta bundle.
module vliw_slot_sequencer
    import vliw_pkg::*;
#(
    parameter int BUNDLE_W = 1024,
    parameter int LANES    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BUNDLE_W-1:0]  in_bundle,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*8-1:0]   out_code,
    output logic [LANES*8-1:0]   out_src,
    output logic [LANES*8-1:0]   out_dst,
    output logic [LANES-1:0]     out_lane_en,
    output logic                 out_last,
    output logic [NEXT_W-1:0]    out_next,
    output logic                 meta_valid,
    input  logic                 meta_ready,
    output logic [OPERAND_W-1:0] meta_operand,
    output logic [NEXT_W-1:0]    meta_next,
    output logic                 len_err
);

    localparam int MAX_SLOTS = max_slots(BUNDLE_W);

    state_t              state_reg, state_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;
    logic [LEN_W-1:0]    n_reg, n_next;
    logic [BUNDLE_W-1:0] bundle_reg, bundle_next;
    logic                len_err_reg, len_err_next;

    logic [LEN_W-1:0]    in_len;
    logic                beat_last;
    logic                in_issue;
    logic                in_meta;
    logic [LANES*8-1:0]  ext_code, ext_src, ext_dst;
    logic [LANES-1:0]    ext_en;

    assign in_len    = in_bundle[BUNDLE_W-LEN_OFS -: LEN_W];
    assign beat_last = ({1'b0, idx_reg} + (IDX_W+1)'(LANES)) >= {2'b00, n_reg};
    assign in_issue  = (state_reg == ISSUE);
    assign in_meta   = (state_reg == META);

    vliw_slot_extract #(
        .BUNDLE_W  (BUNDLE_W),
        .LANES     (LANES),
        .MAX_SLOTS (MAX_SLOTS)
    ) u_extract (
        .bundle (bundle_reg),
        .idx    (idx_reg),
        .n      (n_reg),
        .code   (ext_code),
        .src    (ext_src),
        .dst    (ext_dst),
        .en     (ext_en)
    );

    // State, slot index, captured bundle and clamp flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            n_reg       <= '0;
            bundle_reg  <= '0;
            len_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            n_reg       <= n_next;
            bundle_reg  <= bundle_next;
            len_err_reg <= len_err_next;
        end
    end

    // Next-state: capture on accept, step idx per consumed beat, leave on last
    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        n_next       = n_reg;
        bundle_next  = bundle_reg;
        len_err_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    bundle_next = in_bundle;
                    idx_next    = '0;
                    if (int'(in_len) > MAX_SLOTS) begin
                        n_next       = LEN_W'(MAX_SLOTS);
                        len_err_next = 1'b1;
                    end else begin
                        n_next = in_len;
                    end
                    state_next = in_bundle[BUNDLE_W-META_OFS] ? META : ISSUE;
                end
            end
            ISSUE: begin
                if (out_ready) begin
                    if (beat_last) begin
                        state_next = IDLE;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx_reg + IDX_W'(LANES);
                    end
                end
            end
            META: begin
                if (meta_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs come only from registers; everything is zeroed outside its state
    always_comb begin
        in_ready     = (state_reg == IDLE);
        out_valid    = in_issue;
        out_code     = in_issue ? ext_code : '0;
        out_src      = in_issue ? ext_src  : '0;
        out_dst      = in_issue ? ext_dst  : '0;
        out_lane_en  = in_issue ? ext_en   : '0;
        out_last     = in_issue & beat_last;
        out_next     = in_issue ? bundle_reg[BUNDLE_W-NEXT_OFS -: NEXT_W] : '0;
        meta_valid   = in_meta;
        meta_operand = in_meta ? bundle_reg[BUNDLE_W-OPERAND_OFS -: OPERAND_W] : '0;
        meta_next    = in_meta ? bundle_reg[BUNDLE_W-NEXT_OFS -: NEXT_W] : '0;
        len_err      = len_err_reg;
    end

endmodule

// File: tb/tb_vliw_slot_sequencer.sv
// Directed, table-driven bench for vliw_slot_sequencer (BUNDLE_W=1024, LANES=2).
module tb_vliw_slot_sequencer;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1023:0] in_bundle;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_code, out_src, out_dst;
    logic [1:0]    out_lane_en;
    logic          out_last;
    logic [15:0]   out_next;
    logic          meta_valid;
    logic          meta_ready;
    logic [15:0]   meta_operand, meta_next;
    logic          len_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vliw_slot_sequencer #(.BUNDLE_W(1024), .LANES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_bundle    (in_bundle),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_code     (out_code),
        .out_src      (out_src),
        .out_dst      (out_dst),
        .out_lane_en  (out_lane_en),
        .out_last     (out_last),
        .out_next     (out_next),
        .meta_valid   (meta_valid),
        .meta_ready   (meta_ready),
        .meta_operand (meta_operand),
        .meta_next    (meta_next),
        .len_err      (len_err)
    );

    typedef struct {
        logic [6:0] len;
        int         beats;
        logic [1:0] last_en;
        logic       err;
    } vec_t;

    typedef struct {
        logic [1:0]  en;
        logic [15:0] code;
        logic [15:0] src;
        logic [15:0] dst;
        logic        last;
    } beat_t;

    vec_t  vtab [9];
    beat_t btab [3];

    int         d_beats;
    logic [1:0] d_last_en;
    logic       d_last;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Slot i carries code=i+1, src=0x40+i, dst=0x80+i
    function automatic logic [1023:0] make_bundle(input logic meta, input logic [6:0] len,
                                                  input logic [15:0] opnd, input logic [15:0] nxt);
        logic [1023:0] b;
        b = '0;
        b[1023]       = meta;
        b[1022:1016]  = len;
        b[1015:1000]  = opnd;
        b[999:984]    = nxt;
        for (int i = 0; i < 41; i++) begin
            b[24*i +: 24] = {8'(i + 1), 8'(i + 8'h40), 8'(i + 8'h80)};
        end
        return b;
    endfunction

    task automatic accept(input logic [1023:0] b);
        chk("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
        in_bundle = b;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        in_bundle = '0;
    endtask

    // Consume beats until out_valid drops, optionally stalling one beat
    task automatic drain(input int stall_beat, input int stall_cycles,
                         input logic use_tab, input logic [15:0] exp_next);
        int cyc;
        int stall;
        cyc     = 0;
        stall   = 0;
        d_beats = 0;
        d_last_en = 2'b11;
        d_last    = 1'b0;
        while (out_valid && cyc < 200) begin
            $display("beat %0d: lane_en=%b code=%h src=%h dst=%h last=%b next=%h",
                     d_beats, out_lane_en, out_code, out_src, out_dst, out_last, out_next);
            chk("out_next", {48'd0, out_next}, {48'd0, exp_next});
            if (use_tab && d_beats < 3) begin
                chk("beat_lane_en", {62'd0, out_lane_en}, {62'd0, btab[d_beats].en});
                chk("beat_code", {48'd0, out_code}, {48'd0, btab[d_beats].code});
                chk("beat_src", {48'd0, out_src}, {48'd0, btab[d_beats].src});
                chk("beat_dst", {48'd0, out_dst}, {48'd0, btab[d_beats].dst});
                chk("beat_last", {63'd0, out_last}, {63'd0, btab[d_beats].last});
            end
            if (d_beats == stall_beat && stall < stall_cycles) begin
                out_ready = 1'b0;
                stall++;
            end else begin
                out_ready = 1'b1;
                d_last_en = out_lane_en;
                d_last    = out_last;
                d_beats++;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        if (cyc >= 200) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d cycles expected=<200", cyc);
        end
    endtask

    initial begin
        logic [1023:0] b5;

        vtab[0] = '{len: 7'd5,   beats: 3,  last_en: 2'b01, err: 1'b0};
        vtab[1] = '{len: 7'd4,   beats: 2,  last_en: 2'b11, err: 1'b0};
        vtab[2] = '{len: 7'd0,   beats: 1,  last_en: 2'b00, err: 1'b0};
        vtab[3] = '{len: 7'd1,   beats: 1,  last_en: 2'b01, err: 1'b0};
        vtab[4] = '{len: 7'd2,   beats: 1,  last_en: 2'b11, err: 1'b0};
        vtab[5] = '{len: 7'd41,  beats: 21, last_en: 2'b01, err: 1'b0};
        vtab[6] = '{len: 7'd42,  beats: 21, last_en: 2'b01, err: 1'b1};
        vtab[7] = '{len: 7'd100, beats: 21, last_en: 2'b01, err: 1'b1};
        vtab[8] = '{len: 7'd127, beats: 21, last_en: 2'b01, err: 1'b1};

        btab[0] = '{en: 2'b11, code: 16'h0201, src: 16'h4140, dst: 16'h8180, last: 1'b0};
        btab[1] = '{en: 2'b11, code: 16'h0403, src: 16'h4342, dst: 16'h8382, last: 1'b0};
        btab[2] = '{en: 2'b01, code: 16'h0005, src: 16'h0044, dst: 16'h0084, last: 1'b1};

        b5 = make_bundle(1'b0, 7'd5, 16'h0000, 16'h1234);

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_bundle  = '0;
        out_ready  = 1'b0;
        meta_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_meta_valid", {63'd0, meta_valid}, 64'd0);
        chk("rst_len_err", {63'd0, len_err}, 64'd0);
        chk("rst_out_next", {48'd0, out_next}, 64'd0);
        chk("rst_out_code", {48'd0, out_code}, 64'd0);

        // Beat-exact issue of a five-slot bundle
        accept(b5);
        chk("issue_latency", {63'd0, out_valid}, 64'd1);
        chk("issue_in_ready", {63'd0, in_ready}, 64'd0);
        drain(-1, 0, 1'b1, 16'h1234);
        $display("bundle len=5: beats=%0d", d_beats);
        chk("len5_beats", d_beats, 64'd3);
        chk("len5_gap_in_ready", {63'd0, in_ready}, 64'd1);

        // Same bundle, beat 2 stalled for three cycles
        accept(b5);
        drain(1, 3, 1'b1, 16'h1234);
        $display("bundle len=5 stalled: beats=%0d", d_beats);
        chk("stall_beats", d_beats, 64'd3);

        // Length table, including the clamp boundary
        for (int v = 0; v < 9; v++) begin
            accept(make_bundle(1'b0, vtab[v].len, 16'h0000, 16'h1234));
            chk("tab_out_valid", {63'd0, out_valid}, 64'd1);
            chk("tab_len_err", {63'd0, len_err}, {63'd0, vtab[v].err});
            @(negedge clk);
            chk("tab_len_err_pulse", {63'd0, len_err}, 64'd0);
            drain(-1, 0, 1'b0, 16'h1234);
            $display("bundle len=%0d: beats=%0d last_en=%b last=%b",
                     vtab[v].len, d_beats, d_last_en, d_last);
            chk("tab_beats", d_beats, vtab[v].beats);
            chk("tab_last_en", {62'd0, d_last_en}, {62'd0, vtab[v].last_en});
            chk("tab_last_flag", {63'd0, d_last}, 64'd1);
            chk("tab_gap_in_ready", {63'd0, in_ready}, 64'd1);
        end

        // Meta bundle with meta_ready held low for two cycles
        accept(make_bundle(1'b1, 7'd3, 16'hBEEF, 16'h0042));
        for (int c = 0; c < 3; c++) begin
            $display("meta cycle %0d: meta_valid=%b operand=%h next=%h out_valid=%b",
                     c, meta_valid, meta_operand, meta_next, out_valid);
            chk("meta_valid", {63'd0, meta_valid}, 64'd1);
            chk("meta_operand", {48'd0, meta_operand}, 64'hBEEF);
            chk("meta_next", {48'd0, meta_next}, 64'h0042);
            chk("meta_no_out_valid", {63'd0, out_valid}, 64'd0);
            chk("meta_in_ready", {63'd0, in_ready}, 64'd0);
            meta_ready = (c == 2);
            @(negedge clk);
        end
        meta_ready = 1'b0;
        chk("meta_done_valid", {63'd0, meta_valid}, 64'd0);
        chk("meta_done_in_ready", {63'd0, in_ready}, 64'd1);
        chk("meta_done_operand", {48'd0, meta_operand}, 64'd0);

        // Reset mid-issue, with a competing bundle offered during reset
        accept(b5);
        chk("rst_seq_beat1", {48'd0, out_code}, 64'h0201);
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_seq_beat2", {48'd0, out_code}, 64'h0403);
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_bundle = b5;
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_bundle = '0;
        out_ready = 1'b0;
        $display("after mid-issue reset: out_valid=%b in_ready=%b", out_valid, in_ready);
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("midrst_lane_en", {62'd0, out_lane_en}, 64'd0);
        chk("midrst_code", {48'd0, out_code}, 64'd0);
        @(negedge clk);
        chk("midrst_stays_idle", {63'd0, out_valid}, 64'd0);
        accept(b5);
        drain(-1, 0, 1'b1, 16'h1234);
        chk("midrst_restart_beats", d_beats, 64'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
